// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the digitizer reset sequencer.
package reset_seq_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_REL_CORE  = 3'd2,
    S_REL_HMC   = 3'd3,
    S_RUN       = 3'd4
  } seq_state_t;

  // One counter width covers the hold time, the stage spacing and the watchdog.
  function automatic int cnt_width(input int hold_cycles, input int stage_delay,
                                   input int wdog_timeout);
    int m;
    m = hold_cycles;
    if (stage_delay > m) m = stage_delay;
    if (wdog_timeout > m) m = wdog_timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// SYNC_STAGES-deep single-bit synchronizer with synchronous reset to 0.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic q_out
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d_in};

  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // the chain is reset too so a stale lock or toggle cannot leak past RST.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset release (core, HMC, datapath) after PLL lock, with HMC clock watchdog.
// Optional abort event counter enabled by defining RSTSEQ_EVENT_CNT_EN.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES  = 16,
  parameter int STAGE_DELAY  = 1024,
  parameter int WDOG_TIMEOUT = 256,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SOFT_RST_REQ,
  input  logic                   LOCK_IN,
  input  logic                   HMC_ALIVE_TGL,
  output logic                   RST_CORE,
  output logic                   RST_HMC,
  output logic                   RST_DATAPATH,
  output logic                   SEQ_DONE,
  output logic                   CLK_LOSS,
  output logic [SEQ_STATE_W-1:0] SEQ_STATE
`ifdef RSTSEQ_EVENT_CNT_EN
  ,
  output logic [7:0]             RESEQ_COUNT
`endif
);

  localparam int CW = cnt_width(HOLD_CYCLES, STAGE_DELAY, WDOG_TIMEOUT);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] WDOG_LAST  = CW'(WDOG_TIMEOUT - 1);

  logic lock_s, tgl_s, tgl_edge;
  logic tgl_dly_q, tgl_dly_d;

  seq_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0] wdog_q, wdog_d, wdog_inc;
  logic          seen_q, seen_d;
  logic          clk_loss_q, clk_loss_d;
  logic          rst_core_q, rst_core_d;
  logic          rst_hmc_q, rst_hmc_d;
  logic          rst_dp_q, rst_dp_d;
  logic          seq_done_q, seq_done_d;
  logic          wdog_active, wdog_fire, abort_evt;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lock (
    .clk(CLK), .rst(RST), .d_in(LOCK_IN), .q_out(lock_s)
  );

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tgl (
    .clk(CLK), .rst(RST), .d_in(HMC_ALIVE_TGL), .q_out(tgl_s)
  );

  assign tgl_edge = tgl_s ^ tgl_dly_q;

  // NOTE: every variable gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clk_loss_d = clk_loss_q;
    abort_evt  = 1'b0;
    tgl_dly_d  = tgl_s;
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    wdog_inc   = (wdog_q == '1) ? wdog_q : wdog_q + CW'(1);
    wdog_active = (state_q == S_REL_HMC) || (state_q == S_RUN);
    wdog_fire   = wdog_active && (wdog_q == WDOG_LAST) && !tgl_edge;

    if (SOFT_RST_REQ) begin
      state_d    = S_HOLD;
      cnt_d      = '0;
      clk_loss_d = 1'b0;
    end else if (!lock_s && (state_q == S_REL_CORE || state_q == S_REL_HMC ||
                             state_q == S_RUN)) begin
      state_d   = S_HOLD;
      cnt_d     = '0;
      abort_evt = 1'b1;
    end else if (wdog_fire) begin
      state_d    = S_HOLD;
      cnt_d      = '0;
      clk_loss_d = 1'b1;
      abort_evt  = 1'b1;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else cnt_d = cnt_inc;
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = S_REL_CORE;
            cnt_d   = '0;
          end
        end
        S_REL_CORE: begin
          if (cnt_q == STAGE_LAST) begin
            state_d = S_REL_HMC;
            cnt_d   = '0;
          end else cnt_d = cnt_inc;
        end
        S_REL_HMC: begin
          if (cnt_q >= STAGE_LAST && (seen_q || tgl_edge)) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else if (cnt_q < STAGE_LAST) cnt_d = cnt_inc;
        end
        S_RUN: ;
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      endcase
    end

    // Watchdog restarts on any state change and on every toggle edge.
    if ((state_d == S_REL_HMC || state_d == S_RUN) && state_d == state_q && !tgl_edge)
      wdog_d = wdog_inc;
    else
      wdog_d = '0;

    seen_d     = (state_q == S_REL_HMC) && (seen_q || tgl_edge);
    rst_core_d = (state_d == S_HOLD) || (state_d == S_WAIT_LOCK);
    rst_hmc_d  = rst_core_d || (state_d == S_REL_CORE);
    rst_dp_d   = (state_d != S_RUN);
    seq_done_d = (state_d == S_RUN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_HOLD;
      cnt_q      <= '0;
      wdog_q     <= '0;
      seen_q     <= 1'b0;
      tgl_dly_q  <= 1'b0;
      clk_loss_q <= 1'b0;
      rst_core_q <= 1'b1;
      rst_hmc_q  <= 1'b1;
      rst_dp_q   <= 1'b1;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wdog_q     <= wdog_d;
      seen_q     <= seen_d;
      tgl_dly_q  <= tgl_dly_d;
      clk_loss_q <= clk_loss_d;
      rst_core_q <= rst_core_d;
      rst_hmc_q  <= rst_hmc_d;
      rst_dp_q   <= rst_dp_d;
      seq_done_q <= seq_done_d;
    end
  end

  assign RST_CORE     = rst_core_q;
  assign RST_HMC      = rst_hmc_q;
  assign RST_DATAPATH = rst_dp_q;
  assign SEQ_DONE     = seq_done_q;
  assign CLK_LOSS     = clk_loss_q;
  assign SEQ_STATE    = state_q;

`ifdef RSTSEQ_EVENT_CNT_EN
  logic [7:0] reseq_cnt_q, reseq_cnt_d;

  always_comb begin
    reseq_cnt_d = reseq_cnt_q;
    if (abort_evt && reseq_cnt_q != 8'hFF) reseq_cnt_d = reseq_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) reseq_cnt_q <= '0;
    else     reseq_cnt_q <= reseq_cnt_d;
  end

  assign RESEQ_COUNT = reseq_cnt_q;
`else
  // Without the event counter, lock-loss and watchdog aborts are not tallied.
  logic unused_abort_evt;
  assign unused_abort_evt = abort_evt;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized bench for reset_sequencer with a timestamp-based reference model.
module tb_reset_sequencer;

  localparam int HOLD  = 4;
  localparam int STAGE = 8;
  localparam int WDOG  = 16;
  localparam int SYNC  = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SOFT_RST_REQ = 1'b0;
  logic       LOCK_IN = 1'b1;
  logic       HMC_ALIVE_TGL = 1'b0;
  logic       RST_CORE, RST_HMC, RST_DATAPATH, SEQ_DONE, CLK_LOSS;
  logic [2:0] SEQ_STATE;
`ifdef RSTSEQ_EVENT_CNT_EN
  logic [7:0] RESEQ_COUNT;
`endif

  reset_sequencer #(
    .HOLD_CYCLES(HOLD), .STAGE_DELAY(STAGE), .WDOG_TIMEOUT(WDOG), .SYNC_STAGES(SYNC)
  ) dut (
    .CLK(CLK), .RST(RST), .SOFT_RST_REQ(SOFT_RST_REQ), .LOCK_IN(LOCK_IN),
    .HMC_ALIVE_TGL(HMC_ALIVE_TGL), .RST_CORE(RST_CORE), .RST_HMC(RST_HMC),
    .RST_DATAPATH(RST_DATAPATH), .SEQ_DONE(SEQ_DONE), .CLK_LOSS(CLK_LOSS),
    .SEQ_STATE(SEQ_STATE)
`ifdef RSTSEQ_EVENT_CNT_EN
    , .RESEQ_COUNT(RESEQ_COUNT)
`endif
  );

  initial forever #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase number plus timestamps of state entry and last watchdog clear.
  int  cyc = 0;
  int  m_st = 0, t_enter = 0, t_wd = 0, m_reseq = 0;
  bit  m_seen = 0, m_loss = 0, model_valid = 0;
  bit  lock_p [SYNC];
  bit  tgl_p  [SYNC+1];

  always @(posedge CLK) begin
    bit lk, ed, active;
    int ns;
    cyc++;
    lk = lock_p[SYNC-1];
    ed = tgl_p[SYNC-1] ^ tgl_p[SYNC];
    if (RST) begin
      m_st = 0; t_enter = cyc; t_wd = cyc; m_seen = 0; m_loss = 0; m_reseq = 0;
      foreach (lock_p[i]) lock_p[i] = 1'b0;
      foreach (tgl_p[i]) tgl_p[i] = 1'b0;
      model_valid = 1;
    end else begin
      for (int i = SYNC - 1; i > 0; i--) lock_p[i] = lock_p[i-1];
      lock_p[0] = LOCK_IN;
      for (int i = SYNC; i > 0; i--) tgl_p[i] = tgl_p[i-1];
      tgl_p[0] = HMC_ALIVE_TGL;

      active = (m_st == 3 || m_st == 4);
      if (m_st == 3 && ed) m_seen = 1;
      if (ed) t_wd = cyc;
      ns = m_st;
      if (SOFT_RST_REQ) begin
        ns = 0; m_loss = 0;
      end else if (!lk && m_st >= 2) begin
        ns = 0; if (m_reseq < 255) m_reseq++;
      end else if (active && (cyc - t_wd) >= WDOG) begin
        ns = 0; m_loss = 1; if (m_reseq < 255) m_reseq++;
      end else begin
        case (m_st)
          0: if (cyc - t_enter >= HOLD) ns = 1;
          1: if (lk) ns = 2;
          2: if (cyc - t_enter >= STAGE) ns = 3;
          3: if (cyc - t_enter >= STAGE && m_seen) ns = 4;
          default: ;
        endcase
      end
      if (ns != m_st || SOFT_RST_REQ) begin
        t_enter = cyc; t_wd = cyc; m_seen = 0;
      end
      m_st = ns;
    end
  end

  always @(negedge CLK) begin
    if (model_valid) begin
      check("state", SEQ_STATE, m_st);
      check("rst_core", RST_CORE, m_st <= 1);
      check("rst_hmc", RST_HMC, m_st <= 2);
      check("rst_datapath", RST_DATAPATH, m_st != 4);
      check("seq_done", SEQ_DONE, m_st == 4);
      check("clk_loss", CLK_LOSS, m_loss);
`ifdef RSTSEQ_EVENT_CNT_EN
      check("reseq_count", RESEQ_COUNT, m_reseq);
`endif
    end
  end

  // HMC toggle source: flips every tgl_period cycles while enabled.
  bit tgl_en = 1;
  int tgl_period = 4;
  int tgl_ctr = 0;
  initial forever begin
    @(negedge CLK);
    if (tgl_en) begin
      tgl_ctr++;
      if (tgl_ctr >= tgl_period) begin
        HMC_ALIVE_TGL = ~HMC_ALIVE_TGL;
        tgl_ctr = 0;
      end
    end
  end

  task automatic wait_state(input string name, input int target, input int budget);
    int n = 0;
    while (SEQ_STATE != target[2:0] && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(name, SEQ_STATE, target);
  endtask

  task automatic check_reseq(input string name, input int exp);
`ifdef RSTSEQ_EVENT_CNT_EN
    check(name, RESEQ_COUNT, exp);
`endif
  endtask

  initial begin
    int n;
    // 1. power-up sequence timing
    repeat (3) @(negedge CLK);
    check("reset_state", SEQ_STATE, 0);
    check("reset_core", RST_CORE, 1);
    check("reset_dp", RST_DATAPATH, 1);
    check("reset_loss", CLK_LOSS, 0);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    check("pu_wait_lock", SEQ_STATE, 1);
    check("pu_core_held", RST_CORE, 1);
    @(negedge CLK);
    check("pu_core_fall", RST_CORE, 0);
    check("pu_rel_core", SEQ_STATE, 2);
    repeat (7) @(negedge CLK);
    check("pu_hmc_held", RST_HMC, 1);
    @(negedge CLK);
    check("pu_hmc_fall", RST_HMC, 0);
    check("pu_rel_hmc", SEQ_STATE, 3);
    repeat (7) @(negedge CLK);
    check("pu_done_low", SEQ_DONE, 0);
    @(negedge CLK);
    check("pu_done", SEQ_DONE, 1);
    check("pu_dp_fall", RST_DATAPATH, 0);
    check("pu_run", SEQ_STATE, 4);

    // 2. no lock for 50 cycles
    RST = 1'b1; LOCK_IN = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (50) @(negedge CLK);
    check("nolock_state", SEQ_STATE, 1);
    check("nolock_core", RST_CORE, 1);
    check("nolock_dp", RST_DATAPATH, 1);
    LOCK_IN = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (RST_CORE && n < 3);
    check("lock_core_fall", RST_CORE, 0);
    wait_state("lock_run", 4, 40);

    // 3. one-cycle lock drop
    LOCK_IN = 1'b0;
    n = 0;
    do begin
      @(negedge CLK); n++;
      if (n == 1) LOCK_IN = 1'b1;
    end while (!RST_CORE && n < 3);
    check("drop_core", RST_CORE, 1);
    check("drop_hmc", RST_HMC, 1);
    check("drop_dp", RST_DATAPATH, 1);
    check("drop_done", SEQ_DONE, 0);
    check("drop_loss", CLK_LOSS, 0);
    check_reseq("drop_reseq", 1);
    wait_state("drop_rerun", 4, 60);

    // 4. HMC toggling stops
    tgl_en = 0;
    n = 0;
    while (!CLK_LOSS && n < 30) begin @(negedge CLK); n++; end
    check("wd_loss", CLK_LOSS, 1);
    check("wd_hold", SEQ_STATE, 0);
    wait_state("wd_stall_enter", 3, 30);
    repeat (10) @(negedge CLK);
    check("wd_stalled", SEQ_STATE, 3);
    wait_state("wd_second", 0, 20);
    check("wd_loss2", CLK_LOSS, 1);
    check_reseq("wd_reseq", 3);

    // 5. soft request in S_REL_CORE clears CLK_LOSS
    wait_state("soft_rel_core", 2, 20);
    SOFT_RST_REQ = 1'b1;
    @(negedge CLK);
    check("soft_hold", SEQ_STATE, 0);
    check("soft_loss_clr", CLK_LOSS, 0);
    check_reseq("soft_reseq", 3);
    SOFT_RST_REQ = 1'b0;
    tgl_en = 1;

    // 6. edges exactly at the watchdog terminal count, then RST in S_REL_HMC
    wait_state("tc_run", 4, 60);
    tgl_period = 16;
    repeat (80) @(negedge CLK);
    check("tc_no_timeout", SEQ_STATE, 4);
    check("tc_no_loss", CLK_LOSS, 0);
    tgl_period = 4;
    SOFT_RST_REQ = 1'b1;
    @(negedge CLK);
    SOFT_RST_REQ = 1'b0;
    wait_state("mid_rel_hmc", 3, 40);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("mid_rst_state", SEQ_STATE, 0);
    check("mid_rst_core", RST_CORE, 1);
    check("mid_rst_hmc", RST_HMC, 1);
    check("mid_rst_dp", RST_DATAPATH, 1);
    check("mid_rst_done", SEQ_DONE, 0);
    check_reseq("mid_rst_reseq", 0);
    RST = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      @(negedge CLK);
      r = $urandom_range(0, 999);
      SOFT_RST_REQ = (r < 3);
      RST = (r >= 3 && r < 5);
      if (LOCK_IN) begin
        if (r >= 10 && r < 14) LOCK_IN = 1'b0;
      end else if (r < 200) LOCK_IN = 1'b1;
      if (r >= 20 && r < 26) tgl_en = ~tgl_en;
      if (r >= 30 && r < 40) tgl_period = $urandom_range(2, 18);
    end
    SOFT_RST_REQ = 1'b0;
    RST = 1'b0;
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumes the Main_CLOCK domain and Main_RESET_N produced by the clock/reset block.
- Releases the digitizer subsystems from reset in a fixed order, after PLL lock, with programmable spacing: core logic, then the HMC interface, then the datapath.
- Runs a liveness watchdog on the HMC clock. Loss of lock, a dead HMC clock or a software request re-runs the whole sequence.

Parameters:
- HOLD_CYCLES, 16: minimum cycles all resets stay asserted in S_HOLD.
- STAGE_DELAY, 1024: cycles between successive stage releases.
- WDOG_TIMEOUT, 256: cycles without an HMC toggle edge that count as clock loss.
- SYNC_STAGES, 2: flop depth of each input synchronizer (minimum 2).

Ports:
- CLK in 1: Main_CLOCK domain.
- RST in 1: synchronous, active-high reset.
- SOFT_RST_REQ in 1: one-cycle request, synchronous to CLK.
- LOCK_IN in 1: asynchronous PLL lock.
- HMC_ALIVE_TGL in 1: asynchronous; toggles once per N HMC_CLK cycles, driven from the HMC domain.
- RST_CORE out 1: active-high reset for the core logic.
- RST_HMC out 1: active-high reset for the HMC interface.
- RST_DATAPATH out 1: active-high reset for the datapath.
- SEQ_DONE out 1: sequence complete.
- CLK_LOSS out 1: sticky watchdog flag.
- SEQ_STATE out 3: current FSM state.

Behaviour:
- Interface (already decided): one clock, CLK; reset RST is synchronous and active-high.
- RST=1 puts the block into:
  - state S_HOLD;
  - RST_CORE=RST_HMC=RST_DATAPATH=1;
  - SEQ_DONE=0, CLK_LOSS=0;
  - counters and all synchronizer flops at 0.
- Synchronizers:
  - lock_s = LOCK_IN after SYNC_STAGES flops.
  - tgl_s = HMC_ALIVE_TGL after SYNC_STAGES flops, plus one delay flop.
  - edge = tgl_s XOR its delayed copy.
- State encoding: S_HOLD=0, S_WAIT_LOCK=1, S_REL_CORE=2, S_REL_HMC=3, S_RUN=4. Values 5-7 are illegal and go to S_HOLD.
- Outputs are registered and update on the same edge the state register enters a new state:
  - RST_CORE=1 in S_HOLD and S_WAIT_LOCK.
  - RST_HMC=1 in S_HOLD, S_WAIT_LOCK and S_REL_CORE.
  - RST_DATAPATH=1 in every state except S_RUN.
  - SEQ_DONE=1 only in S_RUN.
- Transitions:
  - S_HOLD: stays exactly HOLD_CYCLES cycles, then goes to S_WAIT_LOCK.
  - S_WAIT_LOCK: goes to S_REL_CORE on the first cycle lock_s=1.
  - S_REL_CORE: after STAGE_DELAY cycles, goes to S_REL_HMC.
  - S_REL_HMC: once STAGE_DELAY cycles have elapsed AND at least one edge has been seen since entering S_REL_HMC, goes to S_RUN. Otherwise it waits.
  - S_RUN: terminal until an abort.
- Aborts, from any state except S_HOLD, all going to S_HOLD with all resets reasserted on the next edge. Priority:
  1. SOFT_RST_REQ (also clears CLK_LOSS).
  2. lock_s=0 in S_REL_CORE, S_REL_HMC or S_RUN.
  3. Watchdog timeout in S_REL_HMC or S_RUN (sets CLK_LOSS=1).
  - In S_WAIT_LOCK, lock_s=0 simply holds the state.
  - SOFT_RST_REQ in S_HOLD restarts the HOLD count.
- Watchdog:
  - Active only in S_REL_HMC and S_RUN; cleared on entry to those states and on every edge.
  - Timeout fires when the count reaches WDOG_TIMEOUT-1 with no edge present.
  - An edge arriving in the same cycle as the terminal count wins: no timeout.
- CLK_LOSS is cleared only by RST or SOFT_RST_REQ.
- Counter width is $clog2(max(HOLD_CYCLES, STAGE_DELAY, WDOG_TIMEOUT)+1). The counter never wraps; it saturates if an illegal parameter combination is used.

Optional Feature:
- Macro: RSTSEQ_EVENT_CNT_EN.
- Defined: adds output RESEQ_COUNT [7:0]:
  - counts aborts caused by lock loss or watchdog timeout;
  - saturates at 255;
  - cleared only by RST (SOFT_RST_REQ aborts are not counted).
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package reset_seq_pkg holds:
  - the state enum type seq_state_t with the encodings above;
  - the SEQ_STATE width constant;
  - the function computing the counter width.
- One sub-module, sync_ff: a SYNC_STAGES-deep bit synchronizer with synchronous reset to 0. It is instantiated twice (lock and toggle).

Test Plan:
Bench parameters: HOLD_CYCLES=4, STAGE_DELAY=8, WDOG_TIMEOUT=16, SYNC_STAGES=2.
1. Power-up: LOCK_IN=1 before RST falls, HMC toggle every 4 cycles -> RST_CORE falls 5 cycles after RST falls, RST_HMC 8 cycles later, RST_DATAPATH and SEQ_DONE 8 cycles after that; SEQ_STATE reads 0,1,2,3,4.
2. LOCK_IN held 0 for 50 cycles after reset -> FSM stays in S_WAIT_LOCK with all resets at 1; after LOCK_IN rises, RST_CORE falls within 3 cycles.
3. In S_RUN, LOCK_IN drops for 1 cycle -> within SYNC_STAGES+1 cycles all resets are 1 and SEQ_DONE=0; full sequence reruns; CLK_LOSS stays 0; RESEQ_COUNT=1.
4. In S_RUN, toggling stops -> 16 cycles after the last edge CLK_LOSS=1 and state is S_HOLD; with toggling still stopped, the sequence stalls in S_REL_HMC, then times out again, and RESEQ_COUNT increments each time.
5. SOFT_RST_REQ pulse in S_REL_CORE while CLK_LOSS=1 -> next cycle S_HOLD and CLK_LOSS=0; RESEQ_COUNT unchanged.
6. Edge and watchdog terminal count in the same cycle -> no timeout. RST asserted mid-S_REL_HMC -> all outputs at reset values on the next edge.
